regfile_wb_sched: RTL and testbench

- Write-port scheduler and hazard scoreboard for the 32x32 RegisterFile.
- Shares the single write port (RW/BusW/RegWr) between two writeback requesters: ALU path (A) and load path (M). Uses round-robin arbitration.
- Keeps a per-register busy scoreboard, set at issue and cleared at commit. Stalls issue on RAW/WAW hazards against in-flight destinations.
- Sits between decode/issue, the execute/memory writeback paths, and RegisterFile.

---
 rtl/regfile_wb_sched.sv | 124 ++++++++++++
 tb/tb_regfile_wb_sched.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_sched.sv
// Purpose: write-port scheduler and busy scoreboard for the 32x32 RegisterFile (ALU path A, load path M).
// Latency: grant is combinational; the granted write reaches RW/BusW/RegWr one edge later, busy clears the edge after that.
// Backpressure: requesters hold Vld/Rd/Dat until Rdy; issue is held off by IssStall while any operand or destination is in flight.
module regfile_wb_sched #(
  parameter int AW    = 5,
  parameter int DW    = 32,
  parameter bit RR_EN = 1'b1
) (
  input  logic                Clk,
  input  logic                Rst,
  input  logic                IssVld,
  input  logic [AW-1:0]       IssRs,
  input  logic [AW-1:0]       IssRt,
  input  logic [AW-1:0]       IssRd,
  output logic                IssStall,
  input  logic                Flush,
  input  logic                VldA,
  input  logic [AW-1:0]       RdA,
  input  logic [DW-1:0]       DatA,
  output logic                RdyA,
  input  logic                VldM,
  input  logic [AW-1:0]       RdM,
  input  logic [DW-1:0]       DatM,
  output logic                RdyM,
  output logic [AW-1:0]       RW,
  output logic [DW-1:0]       BusW,
  output logic                RegWr,
  output logic [(1<<AW)-1:0]  BusyVec
);

  localparam int NREG = 1 << AW;

  // Round-robin pointer: which side wins when both request.
  typedef enum logic {PTR_A = 1'b0, PTR_M = 1'b1} ptr_t;

  ptr_t            r_ptr;
  ptr_t            w_ptr_nxt;
  logic [NREG-1:0] r_busy;
  logic [NREG-1:0] w_busy_nxt;
  logic [AW-1:0]   r_rw;
  logic [DW-1:0]   r_busw;
  logic            r_regwr;
  logic            w_gnt_a;
  logic            w_gnt_m;
  logic            w_issue;
  logic [AW-1:0]   w_rd;
  logic [DW-1:0]   w_dat;

  // Grant selection: a lone requester always wins; on a tie, pointer side (RR) or M (fixed). Flush blocks both.
  always_comb begin
    w_gnt_a = 1'b0;
    w_gnt_m = 1'b0;
    if (!Flush) begin
      if (VldA && VldM) begin
        if (RR_EN && (r_ptr == PTR_A)) w_gnt_a = 1'b1;
        else                           w_gnt_m = 1'b1;
      end else begin
        w_gnt_a = VldA;
        w_gnt_m = VldM;
      end
    end
  end

  // Pointer next state: after any grant it points at the side that lost (or was idle).
  always_comb begin
    w_ptr_nxt = r_ptr;
    if (Flush)        w_ptr_nxt = PTR_A;
    else if (w_gnt_a) w_ptr_nxt = PTR_M;
    else if (w_gnt_m) w_ptr_nxt = PTR_A;
  end

  // Pointer state register.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) r_ptr <= PTR_A;
    else      r_ptr <= w_ptr_nxt;
  end

  assign RdyA  = w_gnt_a;
  assign RdyM  = w_gnt_m;
  assign w_rd  = w_gnt_m ? RdM  : RdA;
  assign w_dat = w_gnt_m ? DatM : DatA;

  // Bit 0 of the scoreboard never sets, so register 0 never stalls anything.
  assign IssStall = IssVld & (r_busy[IssRs] | r_busy[IssRt] | r_busy[IssRd]);
  assign w_issue  = IssVld & ~IssStall & (IssRd != '0) & ~Flush;

  // Scoreboard next state: clear on commit, then set on issue (set wins), flush wipes everything.
  always_comb begin
    w_busy_nxt = r_busy;
    if (r_regwr) w_busy_nxt[r_rw] = 1'b0;
    if (w_issue) w_busy_nxt[IssRd] = 1'b1;
    if (Flush)   w_busy_nxt = '0;
    w_busy_nxt[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) r_busy <= '0;
    else      r_busy <= w_busy_nxt;
  end

  // Commit stage: capture the granted write; RW/BusW hold when idle, RegWr pulses only for Rd!=0.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_rw    <= '0;
      r_busw  <= '0;
      r_regwr <= 1'b0;
    end else if (Flush) begin
      r_regwr <= 1'b0;
    end else if (w_gnt_a || w_gnt_m) begin
      r_rw    <= w_rd;
      r_busw  <= w_dat;
      r_regwr <= (w_rd != '0);
    end else begin
      r_regwr <= 1'b0;
    end
  end

  assign RW      = r_rw;
  assign BusW    = r_busw;
  assign RegWr   = r_regwr;
  assign BusyVec = r_busy;

endmodule

// File: tb/tb_regfile_wb_sched.sv
// Bench for regfile_wb_sched: round-robin instance plus a fixed-priority instance on the same inputs.
// Inputs are driven at the falling edge; outputs are checked at the falling edge or 1 time unit after it.
// A small RegisterFile model is written from RW/BusW/RegWr to check the committed array contents.
module tb_regfile_wb_sched;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        IssVld;
  logic [4:0]  IssRs, IssRt, IssRd;
  logic        Flush;
  logic        VldA, VldM;
  logic [4:0]  RdA, RdM;
  logic [31:0] DatA, DatM;

  logic        IssStall, RdyA, RdyM, RegWr;
  logic [4:0]  RW;
  logic [31:0] BusW, BusyVec;

  logic        fp_IssStall, fp_RdyA, fp_RdyM, fp_RegWr;
  logic [4:0]  fp_RW;
  logic [31:0] fp_BusW, fp_BusyVec;

  logic [31:0] rf [32];

  int n_pass  = 0;
  int n_total = 0;

  always #5 Clk = ~Clk;

  regfile_wb_sched #(.AW(5), .DW(32), .RR_EN(1'b1)) dut (
    .Clk(Clk), .Rst(Rst), .IssVld(IssVld), .IssRs(IssRs), .IssRt(IssRt), .IssRd(IssRd),
    .IssStall(IssStall), .Flush(Flush),
    .VldA(VldA), .RdA(RdA), .DatA(DatA), .RdyA(RdyA),
    .VldM(VldM), .RdM(RdM), .DatM(DatM), .RdyM(RdyM),
    .RW(RW), .BusW(BusW), .RegWr(RegWr), .BusyVec(BusyVec)
  );

  regfile_wb_sched #(.AW(5), .DW(32), .RR_EN(1'b0)) u_fp (
    .Clk(Clk), .Rst(Rst), .IssVld(IssVld), .IssRs(IssRs), .IssRt(IssRt), .IssRd(IssRd),
    .IssStall(fp_IssStall), .Flush(Flush),
    .VldA(VldA), .RdA(RdA), .DatA(DatA), .RdyA(fp_RdyA),
    .VldM(VldM), .RdM(RdM), .DatM(DatM), .RdyM(fp_RdyM),
    .RW(fp_RW), .BusW(fp_BusW), .RegWr(fp_RegWr), .BusyVec(fp_BusyVec)
  );

  // RegisterFile model: register 0 is hardwired to zero.
  always @(posedge Clk) begin
    if (RegWr && (RW != 5'd0)) rf[RW] <= BusW;
  end

  task automatic idle_inputs();
    IssVld = 1'b0; IssRs = '0; IssRt = '0; IssRd = '0;
    Flush  = 1'b0;
    VldA = 1'b0; RdA = '0; DatA = '0;
    VldM = 1'b0; RdM = '0; DatM = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    for (int i = 0; i < 32; i++) rf[i] = '0;
    Rst = 1'b0;
    #12;
    n_total++; if (RW !== 5'd0) $display("FAIL reset_rw: got %0d expected 0", RW); else n_pass++;
    n_total++; if (BusW !== 32'd0) $display("FAIL reset_busw: got %h expected 0", BusW); else n_pass++;
    n_total++; if (RegWr !== 1'b0) $display("FAIL reset_regwr: got %b expected 0", RegWr); else n_pass++;
    n_total++; if (BusyVec !== 32'd0) $display("FAIL reset_busy: got %h expected 0", BusyVec); else n_pass++;
    n_total++; if ({IssStall, RdyA, RdyM} !== 3'b000) $display("FAIL reset_comb: got %b expected 000", {IssStall, RdyA, RdyM}); else n_pass++;
    @(negedge Clk);
    Rst = 1'b1;
  endtask

  task automatic test_issue();
    @(negedge Clk);
    IssVld = 1'b1; IssRs = 5'd1; IssRt = 5'd2; IssRd = 5'd3;
    #1;
    n_total++; if (IssStall !== 1'b0) $display("FAIL issue_nostall: got %b expected 0", IssStall); else n_pass++;
    @(negedge Clk);
    IssVld = 1'b0;
    n_total++; if (BusyVec !== 32'h0000_0008) $display("FAIL issue_busy: got %h expected 00000008", BusyVec); else n_pass++;
    IssVld = 1'b1; IssRs = 5'd3; IssRt = 5'd0; IssRd = 5'd0;
    #1;
    n_total++; if (IssStall !== 1'b1) $display("FAIL issue_raw_stall: got %b expected 1", IssStall); else n_pass++;
    IssVld = 1'b1; IssRs = 5'd1; IssRt = 5'd2; IssRd = 5'd3;
    #1;
    n_total++; if (IssStall !== 1'b1) $display("FAIL issue_waw_stall: got %b expected 1", IssStall); else n_pass++;
    IssVld = 1'b0;
  endtask

  task automatic test_commit();
    @(negedge Clk);
    VldA = 1'b1; RdA = 5'd3; DatA = 32'hDEAD_BEEF;
    #1;
    n_total++; if ({RdyA, RdyM} !== 2'b10) $display("FAIL commit_grant: got %b expected 10", {RdyA, RdyM}); else n_pass++;
    @(negedge Clk);
    VldA = 1'b0;
    n_total++; if (RW !== 5'd3) $display("FAIL commit_rw: got %0d expected 3", RW); else n_pass++;
    n_total++; if (BusW !== 32'hDEAD_BEEF) $display("FAIL commit_busw: got %h expected deadbeef", BusW); else n_pass++;
    n_total++; if (RegWr !== 1'b1) $display("FAIL commit_regwr: got %b expected 1", RegWr); else n_pass++;
    n_total++; if (BusyVec !== 32'h0000_0008) $display("FAIL commit_busy_held: got %h expected 00000008", BusyVec); else n_pass++;
    @(negedge Clk);
    n_total++; if (BusyVec !== 32'd0) $display("FAIL commit_busy_clr: got %h expected 0", BusyVec); else n_pass++;
    n_total++; if (rf[3] !== 32'hDEAD_BEEF) $display("FAIL commit_rf3: got %h expected deadbeef", rf[3]); else n_pass++;
    n_total++; if (RegWr !== 1'b0) $display("FAIL commit_regwr_drop: got %b expected 0", RegWr); else n_pass++;
    IssVld = 1'b1; IssRs = 5'd3; IssRt = 5'd0; IssRd = 5'd0;
    #1;
    n_total++; if (IssStall !== 1'b0) $display("FAIL commit_release: got %b expected 0", IssStall); else n_pass++;
    IssVld = 1'b0;
  endtask

  task automatic test_rd0();
    @(negedge Clk);
    VldM = 1'b1; RdM = 5'd0; DatM = 32'h0000_1234;
    #1;
    n_total++; if ({RdyA, RdyM} !== 2'b01) $display("FAIL rd0_grant: got %b expected 01", {RdyA, RdyM}); else n_pass++;
    @(negedge Clk);
    VldM = 1'b0;
    n_total++; if (RegWr !== 1'b0) $display("FAIL rd0_regwr: got %b expected 0", RegWr); else n_pass++;
    n_total++; if (BusyVec !== 32'd0) $display("FAIL rd0_busy: got %h expected 0", BusyVec); else n_pass++;
    @(negedge Clk);
    n_total++; if (rf[0] !== 32'd0) $display("FAIL rd0_rf0: got %h expected 0", rf[0]); else n_pass++;
  endtask

  // A queues Rd 5,7; M queues Rd 6,8. Pointer is at A (last grant was M), so order is A,M,A,M.
  task automatic test_back_to_back();
    logic [4:0]  a_rd [2];
    logic [4:0]  m_rd [2];
    logic [4:0]  exp_rw [4];
    logic [31:0] exp_dat [4];
    int ia = 0;
    int im = 0;
    a_rd[0] = 5'd5; a_rd[1] = 5'd7;
    m_rd[0] = 5'd6; m_rd[1] = 5'd8;
    exp_rw[0] = 5'd5; exp_rw[1] = 5'd6; exp_rw[2] = 5'd7; exp_rw[3] = 5'd8;
    for (int k = 0; k < 4; k++) exp_dat[k] = 32'hC0DE_0000 | 32'(exp_rw[k]);
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      if (i > 0) begin
        n_total++; if (RegWr !== 1'b1) $display("FAIL rr_regwr_%0d: got %b expected 1", i, RegWr); else n_pass++;
        n_total++; if (RW !== exp_rw[i-1]) $display("FAIL rr_rw_%0d: got %0d expected %0d", i, RW, exp_rw[i-1]); else n_pass++;
        n_total++; if (BusW !== exp_dat[i-1]) $display("FAIL rr_busw_%0d: got %h expected %h", i, BusW, exp_dat[i-1]); else n_pass++;
      end
      VldA = (ia < 2); RdA = a_rd[ia % 2]; DatA = 32'hC0DE_0000 | 32'(a_rd[ia % 2]);
      VldM = (im < 2); RdM = m_rd[im % 2]; DatM = 32'hC0DE_0000 | 32'(m_rd[im % 2]);
      if (i < 4) begin
        #1;
        n_total++;
        if ({RdyA, RdyM} !== ((i % 2 == 0) ? 2'b10 : 2'b01))
          $display("FAIL rr_grant_%0d: got %b expected %b", i, {RdyA, RdyM}, (i % 2 == 0) ? 2'b10 : 2'b01);
        else n_pass++;
        if (VldA && VldM) begin
          n_total++; if ({fp_RdyA, fp_RdyM} !== 2'b01) $display("FAIL fp_grant_%0d: got %b expected 01", i, {fp_RdyA, fp_RdyM}); else n_pass++;
        end
        if (RdyA) ia++;
        if (RdyM) im++;
      end
    end
    VldA = 1'b0; VldM = 1'b0;
    @(negedge Clk);
    n_total++; if (RegWr !== 1'b0) $display("FAIL rr_idle_regwr: got %b expected 0", RegWr); else n_pass++;
    n_total++; if (rf[7] !== 32'hC0DE_0007) $display("FAIL rr_rf7: got %h expected c0de0007", rf[7]); else n_pass++;
  endtask

  task automatic test_flush();
    @(negedge Clk);
    IssVld = 1'b1; IssRs = 5'd0; IssRt = 5'd0; IssRd = 5'd4;
    @(negedge Clk);
    IssRd = 5'd9;
    @(negedge Clk);
    IssVld = 1'b0;
    n_total++; if (BusyVec !== 32'h0000_0210) $display("FAIL flush_pre_busy: got %h expected 00000210", BusyVec); else n_pass++;
    VldA = 1'b1; RdA = 5'd4; DatA = 32'h4444_4444; Flush = 1'b1;
    #1;
    n_total++; if ({RdyA, RdyM} !== 2'b00) $display("FAIL flush_rdy: got %b expected 00", {RdyA, RdyM}); else n_pass++;
    @(negedge Clk);
    Flush = 1'b0; VldA = 1'b0;
    n_total++; if (BusyVec !== 32'd0) $display("FAIL flush_busy: got %h expected 0", BusyVec); else n_pass++;
    n_total++; if (RegWr !== 1'b0) $display("FAIL flush_regwr: got %b expected 0", RegWr); else n_pass++;
    @(negedge Clk);
    n_total++; if (rf[4] !== 32'd0) $display("FAIL flush_rf4: got %h expected 0", rf[4]); else n_pass++;
  endtask

  task automatic test_async_reset();
    @(negedge Clk);
    IssVld = 1'b1; IssRs = 5'd0; IssRt = 5'd0; IssRd = 5'd10;
    @(negedge Clk);
    IssVld = 1'b0;
    VldA = 1'b1; RdA = 5'd10; DatA = 32'hAAAA_5555;
    @(posedge Clk);
    #2;
    VldA = 1'b0;
    n_total++; if (RegWr !== 1'b1) $display("FAIL arst_pre_regwr: got %b expected 1", RegWr); else n_pass++;
    Rst = 1'b0;
    #1;
    n_total++; if (RegWr !== 1'b0) $display("FAIL arst_regwr: got %b expected 0", RegWr); else n_pass++;
    n_total++; if (RW !== 5'd0) $display("FAIL arst_rw: got %0d expected 0", RW); else n_pass++;
    n_total++; if (BusW !== 32'd0) $display("FAIL arst_busw: got %h expected 0", BusW); else n_pass++;
    n_total++; if (BusyVec !== 32'd0) $display("FAIL arst_busy: got %h expected 0", BusyVec); else n_pass++;
    @(negedge Clk);
    Rst = 1'b1;
    VldA = 1'b1; RdA = 5'd11; DatA = 32'h1111_1111;
    VldM = 1'b1; RdM = 5'd12; DatM = 32'h2222_2222;
    #1;
    n_total++; if ({RdyA, RdyM} !== 2'b10) $display("FAIL arst_ptr_a: got %b expected 10", {RdyA, RdyM}); else n_pass++;
    @(negedge Clk);
    VldA = 1'b0; VldM = 1'b0;
    n_total++; if (rf[10] !== 32'd0) $display("FAIL arst_rf10_lost: got %h expected 0", rf[10]); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_issue();
    test_commit();
    test_rd0();
    test_back_to_back();
    test_flush();
    test_async_reset();
    repeat (2) @(negedge Clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
